// File: rtl/jrram_if.sv
// jrram_if: control and status bundle for the jrram flip-flop RAM.
//
// Signals:
//   sa    - set address: MAR loads from the data bus on the next edge
//   s     - set: mem[MAR] is written from the data bus on the next edge
//   e     - enable: the RAM drives mem[MAR] onto the data bus
//   inc   - MAR increments on the next edge (sa has priority)
//   ready - high once the RAM accepts accesses
//   mar   - current MAR value, for debug and address display
//
// The shared tri-state data bus is a plain inout port of jrram. It is not
// carried here, so every tri-state driver sits on a module port.
//
// Modports:
//   master - the CPU / sequencer side that issues control strobes
//   slave  - the RAM side
interface jrram_if #(
  parameter int AWIDTH = 8
);

  logic              sa;
  logic              s;
  logic              e;
  logic              inc;
  logic              ready;
  logic [AWIDTH-1:0] mar;

  modport master (
    output sa, s, e, inc,
    input  ready, mar
  );

  modport slave (
    input  sa, s, e, inc,
    output ready, mar
  );

endinterface

// File: rtl/jrram.sv
// jrram: parametrised flip-flop RAM with an internal memory address register
// (MAR). It is addressed and accessed over one shared tri-state data bus.
//
// Parameters:
//   WIDTH  - data word width
//   AWIDTH - MAR width. AWIDTH <= WIDTH, and the MAR loads from bus[AWIDTH-1:0].
//   DEPTH  - number of words. It must stay 2**AWIDTH, so MAR arithmetic
//            wraps naturally.
//
// Ports:
//   clk   - single clock; all state updates on its rising edge
//   rst_n - asynchronous active-low reset
//   bus   - shared data bus. Driven only while e=1 and the RAM is ready;
//           otherwise high-Z.
//   ctl   - jrram_if.slave control/status bundle (sa, s, e, inc, ready, mar)
//
// Optional feature (macro JRRAM_CLEAR_EN):
//   When defined, every release of reset starts a sweep that writes zero to
//   each word, one word per clock. ready stays low until the sweep completes.
//   When undefined, the RAM is usable straight out of reset with ready tied
//   high, and the memory holds whatever it powered up with.
module jrram #(
  parameter int WIDTH  = 8,
  parameter int AWIDTH = 8,
  parameter int DEPTH  = 1 << AWIDTH
) (
  input  logic             clk,
  input  logic             rst_n,
  inout  wire  [WIDTH-1:0] bus,
  jrram_if.slave           ctl
);

  logic [WIDTH-1:0]  mem [DEPTH];
  logic [AWIDTH-1:0] mar_q;
  logic [WIDTH-1:0]  rd_data;
  logic              active;

  logic              wr_en;
  logic [AWIDTH-1:0] wr_addr;
  logic [WIDTH-1:0]  wr_data;

`ifdef JRRAM_CLEAR_EN
  typedef enum logic {
    ST_CLEAR,
    ST_IDLE
  } state_t;

  state_t            state;
  state_t            state_next;
  logic [AWIDTH-1:0] cnt;
  logic [AWIDTH-1:0] cnt_next;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= ST_CLEAR;
      cnt   <= '0;
    end else begin
      state <= state_next;
      cnt   <= cnt_next;
    end
  end

  // The sweep leaves CLEAR on the edge that zeroes the last word.
  always_comb begin
    state_next = state;
    cnt_next   = cnt;
    if (state == ST_CLEAR) begin
      cnt_next = cnt + 1'b1;
      if (cnt == AWIDTH'(DEPTH - 1)) begin
        state_next = ST_IDLE;
      end
    end
  end

  // ready is simply "sweep finished", so it can only drop through reset.
  assign active = (state == ST_IDLE);

  // The sweep owns the write port while it runs; host strobes are ignored.
  always_comb begin
    wr_en   = 1'b0;
    wr_addr = mar_q;
    wr_data = bus;
    if (rst_n) begin
      if (state == ST_CLEAR) begin
        wr_en   = 1'b1;
        wr_addr = cnt;
        wr_data = '0;
      end else begin
        wr_en   = ctl.s;
      end
    end
  end
`else
  assign active = 1'b1;

  always_comb begin
    wr_en   = rst_n && ctl.s;
    wr_addr = mar_q;
    wr_data = bus;
  end
`endif

  // Storage has no reset, so contents survive rst_n. rst_n gates the write
  // enable so that clocks during reset never disturb the memory.
  always_ff @(posedge clk) begin
    if (wr_en) begin
      mem[wr_addr] <= wr_data;
    end
  end

  // sa takes priority over inc. When e is also high, the load sees the
  // RAM's own read-out on the bus.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      mar_q <= '0;
    end else if (active) begin
      if (ctl.sa) begin
        mar_q <= bus[AWIDTH-1:0];
      end else if (ctl.inc) begin
        mar_q <= mar_q + 1'b1;
      end
    end
  end

  assign rd_data   = mem[mar_q];
  assign bus       = (active && ctl.e) ? rd_data : 'z;
  assign ctl.ready = active;
  assign ctl.mar   = mar_q;

endmodule

// File: tb/tb_jrram.sv
// tb_jrram: self-checking bench for jrram with WIDTH=8 and AWIDTH=4.
//
// A behavioural model (word array plus MAR integer) follows every clocked
// access. Directed cases cover basic access, streaming writes, the
// priority rules, bus release, and asynchronous reset. Randomised
// operations then run against the same model. With JRRAM_CLEAR_EN defined,
// the bench also times the zero sweep, including the case where a reset
// interrupts it.
module tb_jrram;

  localparam int WIDTH  = 8;
  localparam int AWIDTH = 4;
  localparam int DEPTH  = 1 << AWIDTH;

  logic             clk      = 1'b0;
  logic             rst_n    = 1'b0;
  logic [WIDTH-1:0] drive    = '0;
  logic             drive_en = 1'b0;
  wire  [WIDTH-1:0] bus;

  jrram_if #(.AWIDTH(AWIDTH)) ctl ();

  jrram #(
    .WIDTH (WIDTH),
    .AWIDTH(AWIDTH)
  ) dut (
    .clk  (clk),
    .rst_n(rst_n),
    .bus  (bus),
    .ctl  (ctl.slave)
  );

  // The bench acts as the external bus master whenever it is not reading.
  assign bus = drive_en ? drive : 'z;

  always #5 clk = ~clk;

  int               tests = 0;
  int               fails = 0;
  int               m_mar = 0;
  logic [WIDTH-1:0] m_mem [DEPTH];
  bit               known [DEPTH];

  task automatic checkOutput(input string tag, input logic [31:0] got, input logic [31:0] exp);
    tests++;
    if (got !== exp) begin
      fails++;
      $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
    end
  endtask

  task automatic idleInputs();
    ctl.sa   = 1'b0;
    ctl.s    = 1'b0;
    ctl.e    = 1'b0;
    ctl.inc  = 1'b0;
    drive_en = 1'b0;
  endtask

  // One clocked access. The bench drives the bus unless the RAM is asked
  // to. The model applies the rules: the write uses the old address, sa
  // beats inc, and MAR wraps modulo DEPTH.
  task automatic applyStimulus(input bit sa, input bit s, input bit e, input bit inc,
                               input logic [WIDTH-1:0] data);
    logic [WIDTH-1:0] bus_val;
    @(negedge clk);
    ctl.sa   = sa;
    ctl.s    = s;
    ctl.e    = e;
    ctl.inc  = inc;
    drive    = data;
    drive_en = !e;
    @(posedge clk);
    bus_val = e ? m_mem[m_mar] : data;
    if (s) begin
      m_mem[m_mar] = bus_val;
      if (!e) known[m_mar] = 1'b1;
    end
    if (sa)       m_mar = int'(bus_val) % DEPTH;
    else if (inc) m_mar = (m_mar + 1) % DEPTH;
    #1;
  endtask

  // Combinational read of the current word; the bus is released by the bench.
  task automatic readCurrent(input string tag);
    @(negedge clk);
    idleInputs();
    ctl.e = 1'b1;
    #1;
    if (known[m_mar]) checkOutput(tag, bus, m_mem[m_mar]);
  endtask

  task automatic readAll(input string tag);
    for (int a = 0; a < DEPTH; a++) begin
      applyStimulus(1'b1, 1'b0, 1'b0, 1'b0, WIDTH'(a));
      readCurrent(tag);
    end
  endtask

`ifdef JRRAM_CLEAR_EN
  // Release reset and count edges until ready. With stress set, every
  // strobe is held high during the sweep to show that the sweep ignores them.
  task automatic runClear(input bit stress, output int edges);
    @(negedge clk);
    ctl.sa   = stress;
    ctl.s    = stress;
    ctl.e    = stress;
    ctl.inc  = stress;
    drive    = 8'h5A;
    drive_en = stress;
    rst_n    = 1'b1;
    edges    = 0;
    while (edges < 100) begin
      @(posedge clk);
      #1;
      edges++;
      if (ctl.ready) break;
      if (stress) begin
        checkOutput("clear_mar", ctl.mar, 0);
        checkOutput("clear_bus", bus, 8'h5A);
      end
    end
    idleInputs();
    for (int a = 0; a < DEPTH; a++) begin
      m_mem[a] = '0;
      known[a] = 1'b1;
    end
    m_mar = 0;
  endtask
`endif

  initial begin
    #500000;
    $display("[TB] FAIL watchdog: got timeout, expected completion");
    $fatal(1);
  end

  initial begin
    bit               r_sa;
    bit               r_s;
    bit               r_e;
    bit               r_inc;
    logic [WIDTH-1:0] r_data;
    int               edges;

    idleInputs();
    #3;
    checkOutput("reset_mar", ctl.mar, 0);

`ifdef JRRAM_CLEAR_EN
    checkOutput("reset_ready", ctl.ready, 0);
    runClear(1'b1, edges);
    checkOutput("clear_edges", edges, DEPTH);
    readAll("clear_zero");

    // Interrupt the sweep at cnt=7, then confirm that the restart takes a full DEPTH edges.
    @(negedge clk);
    rst_n = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    repeat (7) @(posedge clk);
    #2 rst_n = 1'b0;
    #1;
    checkOutput("midsweep_ready", ctl.ready, 0);
    checkOutput("midsweep_mar", ctl.mar, 0);
    runClear(1'b0, edges);
    checkOutput("restart_edges", edges, DEPTH);
`else
    checkOutput("reset_ready", ctl.ready, 1);
    @(negedge clk);
    rst_n = 1'b1;
`endif

    // Fill every word with a random value by streaming from address 0.
    applyStimulus(1'b1, 1'b0, 1'b0, 1'b0, 8'h00);
    for (int a = 0; a < DEPTH; a++) begin
      applyStimulus(1'b0, 1'b1, 1'b0, 1'b1, WIDTH'($urandom));
    end
    checkOutput("fill_wrap_mar", ctl.mar, 0);
    readAll("fill_read");

    // Basic access
    applyStimulus(1'b1, 1'b0, 1'b0, 1'b0, 8'h05);
    applyStimulus(1'b0, 1'b1, 1'b0, 1'b0, 8'hA7);
    readCurrent("basic_model");
    checkOutput("basic_bus", bus, 8'hA7);
    checkOutput("basic_mar", ctl.mar, 5);
    readAll("basic_keep");

    // Streaming writes across the wrap
    applyStimulus(1'b1, 1'b0, 1'b0, 1'b0, 8'h0E);
    applyStimulus(1'b0, 1'b1, 1'b0, 1'b1, 8'h11);
    applyStimulus(1'b0, 1'b1, 1'b0, 1'b1, 8'h22);
    applyStimulus(1'b0, 1'b1, 1'b0, 1'b1, 8'h33);
    checkOutput("stream_mar", ctl.mar, 1);
    applyStimulus(1'b1, 1'b0, 1'b0, 1'b0, 8'h0E);
    readCurrent("stream_e_model");
    checkOutput("stream_e", bus, 8'h11);
    applyStimulus(1'b1, 1'b0, 1'b0, 1'b0, 8'h0F);
    readCurrent("stream_f_model");
    checkOutput("stream_f", bus, 8'h22);
    applyStimulus(1'b1, 1'b0, 1'b0, 1'b0, 8'h00);
    readCurrent("stream_0_model");
    checkOutput("stream_0", bus, 8'h33);

    // Priority: sa beats inc, and s+sa writes the old address
    applyStimulus(1'b1, 1'b0, 1'b0, 1'b1, 8'h09);
    checkOutput("sa_inc_mar", ctl.mar, 9);
    applyStimulus(1'b1, 1'b0, 1'b0, 1'b0, 8'h03);
    applyStimulus(1'b1, 1'b1, 1'b0, 1'b0, 8'h06);
    checkOutput("s_sa_mar", ctl.mar, 6);
    applyStimulus(1'b1, 1'b0, 1'b0, 1'b0, 8'h03);
    readCurrent("s_sa_model");
    checkOutput("s_sa_word", bus, 8'h06);

    // e+sa follows a pointer stored in the RAM itself
    applyStimulus(1'b1, 1'b0, 1'b0, 1'b0, 8'h02);
    applyStimulus(1'b0, 1'b1, 1'b0, 1'b0, 8'h0C);
    applyStimulus(1'b1, 1'b0, 1'b1, 1'b0, 8'h00);
    checkOutput("e_sa_mar", ctl.mar, 12);

    // With e low the RAM must leave the bus alone while holding a nonzero word
    applyStimulus(1'b0, 1'b1, 1'b0, 1'b0, 8'hC3);
    applyStimulus(1'b0, 1'b0, 1'b0, 1'b0, 8'h00);
    checkOutput("release_bus", bus, 8'h00);
    readCurrent("release_model");
    checkOutput("release_word", bus, 8'hC3);

    // e+s rewrites the same value
    applyStimulus(1'b1, 1'b0, 1'b0, 1'b0, 8'h05);
    applyStimulus(1'b0, 1'b1, 1'b1, 1'b0, 8'h00);
    readCurrent("e_s_model");
    checkOutput("e_s_word", bus, 8'hA7);

    // Randomised operations against the model
    for (int i = 0; i < 300; i++) begin
      r_sa   = ($urandom_range(0, 3) == 0);
      r_s    = ($urandom_range(0, 1) == 1);
      r_e    = ($urandom_range(0, 2) == 0);
      r_inc  = ($urandom_range(0, 1) == 1);
      r_data = WIDTH'($urandom);
      if (!known[m_mar]) r_e = 1'b0;
      applyStimulus(r_sa, r_s, r_e, r_inc, r_data);
      checkOutput("rand_mar", ctl.mar, m_mar);
      if (r_e && known[m_mar]) checkOutput("rand_read", bus, m_mem[m_mar]);
      if (!r_e) checkOutput("rand_release", bus, r_data);
    end
    readAll("rand_final");

    // Asynchronous reset mid-cycle
    applyStimulus(1'b1, 1'b0, 1'b0, 1'b0, 8'h09);
    checkOutput("pre_reset_mar", ctl.mar, 9);
    idleInputs();
    #2 rst_n = 1'b0;
    #1;
    checkOutput("async_mar", ctl.mar, 0);
`ifdef JRRAM_CLEAR_EN
    checkOutput("async_ready", ctl.ready, 0);
    runClear(1'b0, edges);
    checkOutput("reclear_edges", edges, DEPTH);
    readAll("reclear_zero");
`else
    checkOutput("async_ready", ctl.ready, 1);
    @(negedge clk);
    rst_n = 1'b1;
    m_mar = 0;
    readAll("survive_reset");
`endif

    idleInputs();
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule

// File: doc/jrram.md
# jrram

Parametrised flip-flop RAM with an internal memory address register (MAR), addressed and accessed over one shared tri-state bus. It is the next generation of the register and byte storage parts: depth and width are configurable, and it adds address latching, MAR auto-increment and an optional post-reset clear sweep. It sits on the CPU data bus beside the registers and uses the same set/enable signalling.

## Interface
- WIDTH, 8, data word width in bits
- AWIDTH, 8, address width; MAR width; AWIDTH <= WIDTH (MAR loads from bus bits [AWIDTH-1:0])
- DEPTH, 1<<AWIDTH, number of words; fixed to 2^AWIDTH
- clk  input  1  single clock, all state on posedge
- rst_n  input  1  asynchronous, active-low reset
- bus  inout  WIDTH  shared data bus; driven only while e=1 and ready=1, else high-Z
- sa  input  1  set address: MAR <= bus[AWIDTH-1:0] on clock edge
- s  input  1  set: mem[MAR] <= bus on clock edge
- e  input  1  enable: drive mem[MAR] onto bus (combinational)
- inc  input  1  MAR <= MAR+1 on clock edge
- ready  output  1  high when accesses are accepted
- mar  output  AWIDTH  current MAR value (debug / address display)

## Operation
- Reset (rst_n=0, asynchronous): MAR=0, mar=0, bus high-Z, init counter=0; ready=0 with JRRAM_CLEAR_EN, ready=1 without. Memory contents are not touched by the reset itself.
- States: CLEAR (only with JRRAM_CLEAR_EN) and IDLE. Reset enters CLEAR (or IDLE without the macro).
- CLEAR: each edge writes 0 to mem[cnt], cnt <= cnt+1. After the edge writing DEPTH-1, go to IDLE and set ready=1. In CLEAR, sa, s, inc and e are ignored and bus is high-Z.
- IDLE: per edge, independently:
  - s=1 writes bus to mem[MAR], using the pre-edge MAR.
  - sa=1 loads MAR; it has priority over inc.
  - inc=1 (sa=0) increments MAR modulo DEPTH, so DEPTH-1 wraps to 0.
- e=1 in IDLE: bus = mem[MAR] combinationally, holding the current MAR and contents.
- Simultaneous cases:
  - s+inc writes the old address, then advances, giving streaming writes.
  - s+sa writes the old address and loads the new one.
  - e+sa loads MAR from the RAM's own output.
  - e+s rewrites the same value (no change).
  - e with external bus drivers is a system contention error; the block does not arbitrate.
- Reset mid-CLEAR aborts the sweep. The next deassertion restarts it at address 0.

## Timing
- Write latency: data written at edge N is visible on bus via e after edge N (same cycle as MAR update).
- MAR load or increment at edge N: mar and the e read-out reflect the new address after edge N.
- Read: zero-cycle combinational path from MAR/mem to bus when e=1.
- Clear duration: exactly DEPTH rising edges after rst_n deasserts. ready rises after the DEPTH-th edge and is 1 for the following cycle.
- ready never falls except on reset.
- Without the macro, ready=1 throughout and after reset, and the first access may occur on the first edge after deassertion.

## Configuration
- JRRAM_CLEAR_EN defined: the CLEAR state, init counter and zero-write path are compiled in. After reset, all words read 0 once ready=1.
- Undefined: no CLEAR state and no counter. The block is IDLE from reset, ready is tied to 1, and memory contents after power-up are undefined (X in simulation). Contents survive a reset.

## Test plan
- Clear sweep: with macro, WIDTH=8, AWIDTH=4. Release rst_n and count edges -> ready=0 for 16 edges, then 1. Read all 16 addresses via sa/e -> every word 0x00.
- Basic access: sa with bus=0x05, then s with bus=0xA7, then e -> bus=0xA7 and mar=5. Other addresses keep their prior values.
- Streaming writes: MAR=0x0E (AWIDTH=4). Pulse s+inc with data 0x11, 0x22, 0x33 -> mem[E]=0x11, mem[F]=0x22, mem[0]=0x33, and mar ends at 1 (wrap).
- Priority: sa+inc together with bus=0x09 -> mar=9, not 10. s+sa with MAR=3, bus=0x06 -> mem[3]=0x06, mar=6.
- Ignore during clear: assert s, sa, e and inc during CLEAR -> bus high-Z, mar stays 0, and no word is nonzero after ready.
- Reset mid-sweep: assert rst_n=0 asynchronously at cnt=7 -> ready=0 and mar=0 immediately. The sweep restarts and ready rises exactly DEPTH edges after the new deassertion.
